// File: rtl/blitter_pkg.sv
// Shared types and constants for the sprite blitter.
// Widths match the vga_adapter pixel port and the ram_block sprite ROM.
package blitter_pkg;

    localparam int COLOUR_W = 9;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;

    localparam int                  DEF_SCREEN_W    = 160;
    localparam int                  DEF_SCREEN_H    = 120;
    localparam logic [COLOUR_W-1:0] DEF_TRANSPARENT = 9'h1FF;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        FLUSH,
        DONE
    } state_t;

endpackage

// File: rtl/sprite_addr_gen.sv
// Row-major walker over a SPR_W x SPR_H sprite: col/row/idx counters and ROM address.
// Holds its position when advance is low, so the last address stays on the bus.
module sprite_addr_gen
    import blitter_pkg::*;
#(
    parameter int SPR_W  = 16,
    parameter int SPR_H  = 16,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clear,
    input  logic              advance,
    input  logic [ADDR_W-1:0] base,
    output logic [ADDR_W-1:0] addr,
    output logic [X_W-1:0]    col,
    output logic [Y_W-1:0]    row,
    output logic              last
);

    localparam logic [X_W-1:0] COL_LAST = X_W'(SPR_W - 1);
    localparam logic [Y_W-1:0] ROW_LAST = Y_W'(SPR_H - 1);

    logic [ADDR_W-1:0] r_idx;
    logic [X_W-1:0]    r_col;
    logic [Y_W-1:0]    r_row;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_idx <= '0;
            r_col <= '0;
            r_row <= '0;
        end else if (clear) begin
            r_idx <= '0;
            r_col <= '0;
            r_row <= '0;
        end else if (advance) begin
            r_idx <= r_idx + 1'b1;
            if (r_col == COL_LAST) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Address wraps naturally modulo 2**ADDR_W.
    assign addr = base + r_idx;
    assign col  = r_col;
    assign row  = r_row;
    assign last = (r_col == COL_LAST) && (r_row == ROW_LAST);

endmodule

// File: rtl/sprite_blitter.sv
// Copies one sprite from a 1-cycle-latency ROM to the vga_adapter write port.
// First plot two cycles after start; done pulses at N+2; start is ignored while busy.
module sprite_blitter
    import blitter_pkg::*;
#(
    parameter int                  SPR_W       = 16,
    parameter int                  SPR_H       = 16,
    parameter int                  ADDR_W      = 9,
    parameter int                  SCREEN_W    = DEF_SCREEN_W,
    parameter int                  SCREEN_H    = DEF_SCREEN_H,
    parameter logic [COLOUR_W-1:0] TRANSPARENT = DEF_TRANSPARENT
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [X_W-1:0]      x_in,
    input  logic [Y_W-1:0]      y_in,
    input  logic [ADDR_W-1:0]   base_addr,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [COLOUR_W-1:0] rom_q,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot,
    output logic                busy,
    output logic                done
);

    localparam logic [X_W:0] X_LIM = (X_W + 1)'(SCREEN_W);
    localparam logic [Y_W:0] Y_LIM = (Y_W + 1)'(SCREEN_H);

    state_t            r_state;
    logic [X_W-1:0]    r_x0;
    logic [Y_W-1:0]    r_y0;
    logic [ADDR_W-1:0] r_base;
    logic [X_W-1:0]    r_col_d;
    logic [Y_W-1:0]    r_row_d;
    logic              r_valid_d;
    logic              r_busy;
    logic              r_done;

    logic              w_accept;
    logic              w_advance;
    logic [ADDR_W-1:0] w_addr;
    logic [X_W-1:0]    w_col;
    logic [Y_W-1:0]    w_row;
    logic              w_last;
    logic [X_W:0]      w_px;
    logic [Y_W:0]      w_py;

    assign w_accept  = (r_state == IDLE) && start;
    assign w_advance = (r_state == DRAW) && !w_last;

    sprite_addr_gen #(
        .SPR_W  (SPR_W),
        .SPR_H  (SPR_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (w_accept),
        .advance (w_advance),
        .base    (r_base),
        .addr    (w_addr),
        .col     (w_col),
        .row     (w_row),
        .last    (w_last)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_x0    <= '0;
            r_y0    <= '0;
            r_base  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_x0    <= x_in;
                        r_y0    <= y_in;
                        r_base  <= base_addr;
                        r_busy  <= 1'b1;
                        r_state <= DRAW;
                    end
                end
                DRAW: begin
                    if (w_last) begin
                        r_state <= FLUSH;
                    end
                end
                FLUSH: begin
                    r_done  <= 1'b1;
                    r_state <= DONE;
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Delay the pixel coordinates by the ROM read latency so they meet rom_q.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_col_d   <= '0;
            r_row_d   <= '0;
            r_valid_d <= 1'b0;
        end else begin
            r_col_d   <= w_col;
            r_row_d   <= w_row;
            r_valid_d <= (r_state == DRAW);
        end
    end

    assign rom_addr = ((r_state == DRAW) || (r_state == FLUSH)) ? w_addr : '0;

    // One extra bit so pixels past the right/bottom edge clip instead of wrapping.
    assign w_px = {1'b0, r_x0} + {1'b0, r_col_d};
    assign w_py = {1'b0, r_y0} + {1'b0, r_row_d};

    assign vga_x      = w_px[X_W-1:0];
    assign vga_y      = w_py[Y_W-1:0];
    assign vga_colour = r_valid_d ? rom_q : '0;
    assign vga_plot   = r_valid_d && (rom_q != TRANSPARENT) && (w_px < X_LIM) && (w_py < Y_LIM);

    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_sprite_blitter.sv
// Randomised bench for sprite_blitter (4x4 sprite) against a per-cycle expectation model.
module tb_sprite_blitter;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int AW = 9;
    localparam int N  = W * H;
    localparam int ROM_SZ = 1 << AW;

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    x_in = '0;
    logic [6:0]    y_in = '0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] rom_addr;
    logic [8:0]    rom_q = '0;
    logic [7:0]    vga_x;
    logic [6:0]    vga_y;
    logic [8:0]    vga_colour;
    logic          vga_plot;
    logic          busy;
    logic          done;

    logic [8:0] rom [ROM_SZ];

    int n_checks = 0;
    int n_pass   = 0;

    sprite_blitter #(
        .SPR_W  (W),
        .SPR_H  (H),
        .ADDR_W (AW)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .x_in       (x_in),
        .y_in       (y_in),
        .base_addr  (base_addr),
        .rom_addr   (rom_addr),
        .rom_q      (rom_q),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_q <= rom[rom_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"},   32'(rom_addr),   0);
        check({tag, "_x"},      32'(vga_x),      0);
        check({tag, "_y"},      32'(vga_y),      0);
        check({tag, "_colour"}, 32'(vga_colour), 0);
        check({tag, "_plot"},   32'(vga_plot),   0);
        check({tag, "_busy"},   32'(busy),       0);
        check({tag, "_done"},   32'(done),       0);
    endtask

    // One complete blit; every cycle is compared with what the sprite rules imply.
    task automatic blit(input logic [7:0] x, input logic [6:0] y, input logic [AW-1:0] b,
                        output int nplots);
        int k, px, py, a;
        logic [8:0] colr;
        bit pl;
        nplots = 0;
        x_in = x; y_in = y; base_addr = b; start = 1'b1;
        check("pre_busy", 32'(busy), 0);
        tick();
        start = 1'b0;
        x_in = 8'($urandom); y_in = 7'($urandom); base_addr = AW'($urandom);
        for (int c = 1; c <= N + 3; c++) begin
            if (c <= N) begin
                a = (int'(b) + c - 1) % ROM_SZ;
                check($sformatf("addr_c%0d", c), 32'(rom_addr), 32'(a));
            end else if (c == N + 1) begin
                a = (int'(b) + N - 1) % ROM_SZ;
                check("addr_flush", 32'(rom_addr), 32'(a));
            end else if (c == N + 3) begin
                check("addr_idle", 32'(rom_addr), 0);
            end
            check($sformatf("busy_c%0d", c), 32'(busy), 32'(c <= N + 2));
            check($sformatf("done_c%0d", c), 32'(done), 32'(c == N + 2));
            if (c >= 2 && c <= N + 1) begin
                k    = c - 2;
                px   = int'(x) + k % W;
                py   = int'(y) + k / W;
                colr = rom[(int'(b) + k) % ROM_SZ];
                pl   = (colr != 9'h1FF) && (px < 160) && (py < 120);
                check($sformatf("plot_k%0d", k), 32'(vga_plot), 32'(pl));
                if (pl) begin
                    nplots++;
                    check($sformatf("x_k%0d", k),   32'(vga_x),      32'(px % 256));
                    check($sformatf("y_k%0d", k),   32'(vga_y),      32'(py % 128));
                    check($sformatf("col_k%0d", k), 32'(vga_colour), 32'(colr));
                end
            end else begin
                check($sformatf("noplot_c%0d", c), 32'(vga_plot), 0);
            end
            tick();
        end
    endtask

    initial begin
        int np, ph, nacc;
        logic [7:0] rx;
        logic [6:0] ry;

        for (int i = 0; i < ROM_SZ; i++) rom[i] = 9'(i);

        #2 resetn = 1'b0;
        #1 check_all_zero("reset");
        tick(); tick();
        resetn = 1'b1;
        tick();

        blit(8'd10, 7'd20, 9'd0, np);
        check("plots_basic", 32'(np), 16);

        rom[5] = 9'h1FF; rom[9] = 9'h1FF;
        blit(8'd10, 7'd20, 9'd0, np);
        check("plots_transparent", 32'(np), 14);
        rom[5] = 9'd5; rom[9] = 9'd9;

        blit(8'd158, 7'd118, 9'd0, np);
        check("plots_clipped", 32'(np), 4);

        for (int i = 0; i < ROM_SZ; i++) rom[i] = 9'($urandom);
        blit(8'd50, 7'd60, 9'(ROM_SZ - 2), np);

        // Asynchronous reset in DRAW cycle 7, then a fresh full blit.
        x_in = 8'd30; y_in = 7'd40; base_addr = 9'd100; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        #2 resetn = 1'b0;
        #1 check_all_zero("midreset");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midreset_done", 32'(done), 0);
            check("midreset_busy", 32'(busy), 0);
        end
        resetn = 1'b1;
        tick();
        check("after_reset_done", 32'(done), 0);
        blit(8'd30, 7'd40, 9'd100, np);

        // start held high: accepted only from IDLE, one blit at a time.
        ph = -1; nacc = 0;
        start = 1'b1;
        for (int c = 0; c <= 60; c++) begin
            check($sformatf("hold_busy_c%0d", c), 32'(busy), 32'(ph > 0));
            check($sformatf("hold_done_c%0d", c), 32'(done), 32'(ph == N + 2));
            if (c == 40) start = 1'b0;
            if (ph == -1) begin
                if (start) begin
                    ph = 1;
                    nacc++;
                end
            end else if (ph == N + 2) begin
                ph = -1;
            end else begin
                ph++;
            end
            tick();
        end
        check("hold_accepts", 32'(nacc), 3);

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < ROM_SZ; i++)
                rom[i] = ($urandom_range(0, 7) == 0) ? 9'h1FF : 9'($urandom);
            rx = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(150, 159)) : 8'($urandom);
            ry = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(110, 119)) : 7'($urandom);
            blit(rx, ry, 9'($urandom), np);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
